// File: rtl/morse_symbol_sequencer_if.sv
// Key-to-decoder bus of the Morse symbol sequencer.
// master: sequencer side (samples key level and ready, drives symbols, valids, error).
// slave: environment side (drives key level and ready, observes the sequencer).
interface morse_symbol_sequencer_if #(
    parameter int MORSE_CHAR_WIDTH_MAX = 5,
    parameter int MORSE_SIZE_WIDTH_MAX = 3
);
    logic                            btn_i;         // debounced key level, 1 = pressed
    logic                            ready_i;       // decoder accepts char or space
    logic [MORSE_CHAR_WIDTH_MAX-1:0] char_o;        // dot = 0, dash = 1, first symbol in MSB
    logic [MORSE_SIZE_WIDTH_MAX-1:0] size_o;        // number of valid symbols
    logic                            char_valid_o;  // char_o/size_o valid, held until accepted
    logic                            space_valid_o; // word gap seen, held until accepted
    logic                            error_o;       // one-cycle pulse: illegal press or sixth symbol

    modport master (
        input  btn_i,
        input  ready_i,
        output char_o,
        output size_o,
        output char_valid_o,
        output space_valid_o,
        output error_o
    );

    modport slave (
        output btn_i,
        output ready_i,
        input  char_o,
        input  size_o,
        input  char_valid_o,
        input  space_valid_o,
        input  error_o
    );
endinterface

// File: rtl/morse_symbol_sequencer.sv
// Purpose: turns key press/release timing into packed Morse characters, word spaces and error pulses.
// Latency: char_valid_o rises CHAR_TICK_COUNT cycles after the first idle GAP cycle; space after WORD_TICK_COUNT.
// Backpressure: char/space held stable until ready_i; the idle counter keeps running while a char is stalled.
// Ports: clk, rst (sync, active-high); bus (master modport) carries btn_i, ready_i, char_o, size_o,
//        char_valid_o, space_valid_o, error_o.
module morse_symbol_sequencer #(
    parameter int DASH_TICK_COUNT           = 30_000_000,
    parameter int ILLEGAL_SYMBOL_TICK_COUNT = 100_000_000,
    parameter int CHAR_TICK_COUNT           = 175_000_000,
    parameter int WORD_TICK_COUNT           = 250_000_000,
    parameter int MORSE_CHAR_WIDTH_MAX      = 5,
    parameter int MORSE_SIZE_WIDTH_MAX      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    morse_symbol_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(WORD_TICK_COUNT + 1);
    localparam int CW    = MORSE_CHAR_WIDTH_MAX;
    localparam int SW    = MORSE_SIZE_WIDTH_MAX;

    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICK_COUNT);
    localparam logic [CNT_W-1:0] ILL_C  = CNT_W'(ILLEGAL_SYMBOL_TICK_COUNT);
    localparam logic [CNT_W-1:0] CHAR_C = CNT_W'(CHAR_TICK_COUNT);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_TICK_COUNT);
    localparam logic [SW-1:0]    FULL_C = SW'(CW);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESS     = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] CHAR_OUT  = 3'd3;
    localparam logic [2:0] WORD_WAIT = 3'd4;
    localparam logic [2:0] SPACE_OUT = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] press_nxt;
    logic [CNT_W-1:0] idle_nxt;
    logic [CW-1:0]    sym_buf;
    logic [SW-1:0]    sym_cnt;
    logic             char_vld;
    logic             space_vld;
    logic             err;
    // A key already held when reset drops must be released once before it counts.
    logic             armed;

    // Both counters saturate rather than wrap.
    assign press_nxt = (press_cnt == ILL_C)  ? press_cnt : press_cnt + CNT_W'(1);
    assign idle_nxt  = (idle_cnt  == WORD_C) ? idle_cnt  : idle_cnt  + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            press_cnt <= '0;
            idle_cnt  <= '0;
            sym_buf   <= '0;
            sym_cnt   <= '0;
            char_vld  <= 1'b0;
            space_vld <= 1'b0;
            err       <= 1'b0;
            armed     <= 1'b0;
        end else begin
            err <= 1'b0;
            if (!bus.btn_i) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // The sampling cycle is the first pressed cycle, so the count starts at 1.
                    if (bus.btn_i && armed) begin
                        press_cnt <= CNT_W'(1);
                        state     <= PRESS;
                    end
                end
                PRESS: begin
                    if (bus.btn_i) begin
                        press_cnt <= press_nxt;
                        // Fires only on the step into saturation, so one pulse per press.
                        if (press_cnt != ILL_C && press_nxt == ILL_C) begin
                            err     <= 1'b1;
                            sym_buf <= '0;
                            sym_cnt <= '0;
                        end
                    end else if (press_cnt == ILL_C) begin
                        state <= IDLE;
                    end else if (sym_cnt == FULL_C) begin
                        err     <= 1'b1;
                        sym_buf <= '0;
                        sym_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        for (int k = 0; k < CW; k++) begin
                            if (sym_cnt == SW'(k)) begin
                                sym_buf[CW-1-k] <= (press_cnt >= DASH_C);
                            end
                        end
                        sym_cnt  <= sym_cnt + SW'(1);
                        idle_cnt <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (bus.btn_i) begin
                        press_cnt <= CNT_W'(1);
                        state     <= PRESS;
                    end else begin
                        idle_cnt <= idle_nxt;
                        if (idle_nxt == CHAR_C) begin
                            char_vld <= 1'b1;
                            state    <= CHAR_OUT;
                        end
                    end
                end
                CHAR_OUT: begin
                    // Key ignored here; the word timer must keep running while stalled.
                    idle_cnt <= idle_nxt;
                    if (bus.ready_i) begin
                        char_vld <= 1'b0;
                        sym_buf  <= '0;
                        sym_cnt  <= '0;
                        state    <= WORD_WAIT;
                    end
                end
                WORD_WAIT: begin
                    if (bus.btn_i) begin
                        press_cnt <= CNT_W'(1);
                        state     <= PRESS;
                    end else begin
                        idle_cnt <= idle_nxt;
                        // Also true when already saturated after a late char handshake.
                        if (idle_nxt == WORD_C) begin
                            space_vld <= 1'b1;
                            state     <= SPACE_OUT;
                        end
                    end
                end
                SPACE_OUT: begin
                    if (bus.ready_i) begin
                        space_vld <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.char_o        = sym_buf;
    assign bus.size_o        = sym_cnt;
    assign bus.char_valid_o  = char_vld;
    assign bus.space_valid_o = space_vld;
    assign bus.error_o       = err;
endmodule

// File: doc/morse_symbol_sequencer.md
MORSE_SYMBOL_SEQUENCER -- requirements
Module: morse_symbol_sequencer

Interface
REQ-001 The block SHALL have parameter DASH_TICK_COUNT, default 30_000_000, press length in cycles at or above which a symbol is a dash.
REQ-002 The block SHALL have parameter ILLEGAL_SYMBOL_TICK_COUNT, default 100_000_000, press length in cycles at or above which a symbol is illegal.
REQ-003 The block SHALL have parameter CHAR_TICK_COUNT, default 175_000_000, idle cycles that close a character.
REQ-004 The block SHALL have parameter WORD_TICK_COUNT, default 250_000_000, idle cycles that close a word.
REQ-005 The block SHALL have parameters MORSE_CHAR_WIDTH_MAX, default 5, and MORSE_SIZE_WIDTH_MAX, default 3.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high, with ports named as below.
REQ-007 clk  input  1  system clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 btn_i  input  1  debounced key level; 1 = pressed.
REQ-010 ready_i  input  1  downstream decoder accepts char or space this cycle.
REQ-011 char_o  output  MORSE_CHAR_WIDTH_MAX  packed symbols; dot = 0, dash = 1; first symbol in the MSB.
REQ-012 size_o  output  MORSE_SIZE_WIDTH_MAX  number of valid symbols, 1..5.
REQ-013 char_valid_o  output  1  char_o and size_o are valid; held until accepted.
REQ-014 space_valid_o  output  1  word gap detected; held until accepted.
REQ-015 error_o  output  1  one-cycle pulse on an illegal press or a sixth symbol.

Function
REQ-016 The state machine SHALL have these states: IDLE, PRESS, GAP, CHAR_OUT, WORD_WAIT and SPACE_OUT.
REQ-017 Press counter: counts cycles with btn_i=1 in PRESS; saturates at ILLEGAL_SYMBOL_TICK_COUNT.
REQ-018 Idle counter: counts cycles with btn_i=0 in GAP, CHAR_OUT and WORD_WAIT; saturates at WORD_TICK_COUNT.
REQ-019 Both counters SHALL be $clog2(WORD_TICK_COUNT+1) bits wide.
REQ-020 IDLE and GAP: btn_i=1 SHALL clear the press counter and enter PRESS.
REQ-021 Release in PRESS, with N = press length in cycles: N<DASH_TICK_COUNT appends a dot; DASH_TICK_COUNT<=N<ILLEGAL_SYMBOL_TICK_COUNT appends a dash; then clear the idle counter and enter GAP.
REQ-022 Symbol k (0-based) SHALL be written to char_o bit (4-k), and size increments; unwritten bits SHALL stay 0.
REQ-023 Illegal symbol: when the press counter reaches ILLEGAL_SYMBOL_TICK_COUNT, pulse error_o once, clear buffer and size, and on release enter IDLE without appending.
REQ-024 Overflow: a release that would append a sixth symbol SHALL pulse error_o, clear buffer and size, and enter IDLE.
REQ-025 GAP: char_valid_o SHALL rise exactly CHAR_TICK_COUNT cycles after the first cycle btn_i is sampled 0 in GAP; state becomes CHAR_OUT.
REQ-026 CHAR_OUT: char_o and size_o SHALL be stable, and btn_i SHALL be ignored.
REQ-027 CHAR_OUT: the cycle with ready_i=1 completes the transfer; next cycle char_valid_o=0, buffer cleared, state WORD_WAIT; the idle counter SHALL continue counting.
REQ-028 WORD_WAIT: btn_i=1 SHALL enter PRESS.
REQ-029 WORD_WAIT: space_valid_o SHALL rise exactly WORD_TICK_COUNT cycles after the GAP release; if ready_i was late, it rises the cycle after WORD_WAIT entry once the idle counter has saturated.
REQ-030 SPACE_OUT: a cycle with ready_i=1 SHALL clear space_valid_o on the next cycle and enter IDLE.
REQ-031 Only one space SHALL be emitted per idle period; IDLE never emits a space.
REQ-032 char_valid_o and space_valid_o SHALL never be 1 in the same cycle.
REQ-033 error_o SHALL never coincide with either valid.
REQ-034 ready_i SHALL be ignored when no valid is asserted.

Reset
REQ-035 While rst=1: state IDLE; counters, buffer and size 0; char_o=0, size_o=0, char_valid_o=0, space_valid_o=0, error_o=0.
REQ-036 Reset mid-operation SHALL abort the character without output.
REQ-037 After reset, btn_i SHALL be sampled 0 at least once before a press is recognised.

Verification
REQ-038 Bench parameters SHALL be DASH=3, ILLEGAL=10, CHAR=17, WORD=25, with ready_i=1.
REQ-039 Scenario: press 2, release, press 5, release, idle -> char_o=5'b01000, size_o=2, char_valid_o high for 1 cycle at the 17th idle cycle; space_valid_o at the 25th.
REQ-040 Scenario: ready_i=0 held 30 cycles after char_valid_o -> char held stable; space_valid_o rises the cycle after the ready_i handshake.
REQ-041 Scenario: press 10 cycles -> error_o for one cycle; no char_valid_o; the next valid character decodes normally.
REQ-042 Scenario: five dashes then a sixth press -> first five give char_o=5'b11111 only if idle; the sixth release pulses error_o with no output.
REQ-043 Scenario: boundary presses of 2 and 3 cycles -> dot and dash respectively; re-press at idle cycle 16 -> no char emitted, symbol appended.
REQ-044 Scenario: rst asserted mid-press with btn_i held -> all outputs 0; no press recognised until btn_i is sampled 0.
